pipe_decoder: RTL and testbench
===============================

PIPE_DECODER -- requirements
Module: pipe_decoder

Interface
REQ-001 Parameter XLEN, default 32, SHALL set width of PC and immediate paths; legal values 32 and 64; instruction encoding stays RV32.
REQ-002 Parameter EN_M, default 0, SHALL enable decode of M-extension ops when 1; when 0 they SHALL be illegal.
REQ-003 Ports SHALL be:
- i_clk  in  1  single clock; all state changes on rising edge
- i_rst  in  1  reset, asynchronous, active-high
- i_valid  in  1  upstream instruction valid
- o_ready  out  1  stage can accept
- i_instr  in  32  instruction word
- i_pc  in  XLEN  instruction address
- i_flush  in  1  kill held/incoming instruction
- o_valid  out  1  decoded bundle valid
- i_ready  in  1  downstream accepts
- o_pc  out  XLEN  registered PC
- o_imm  out  XLEN  sign-extended immediate
- o_rs1, o_rs2, o_rd  out  5 each  register indices
- o_alu_ctrl  out  5  ALU op code
- o_branch, o_jal, o_jalr, o_selop1, o_selop2, o_wr_en, o_rf_wr  out  1 each  datapath controls
- o_resultsrc  out  2  00 ALU, 01 load, 10 PC+4
- o_illegal  out  1  held instruction undecodable
- o_illegal_cnt  out  16  saturating count of accepted illegal instructions

Function
REQ-004 Stage SHALL be one registered entry; o_ready SHALL equal !o_valid | i_ready (combinational).
REQ-005 Accept SHALL occur when i_valid & o_ready & !i_flush; on accept all outputs SHALL load the decode of i_instr/i_pc and o_valid SHALL be 1 next cycle.
REQ-006 When o_valid & !i_ready, every output SHALL hold stable.
REQ-007 When o_valid & i_ready and no accept, o_valid SHALL drop to 0 next cycle.
REQ-008 i_flush SHALL override accept: o_valid SHALL be 0 next cycle, no load, counter unchanged.
REQ-009 Latency SHALL be exactly 1 cycle accept-to-o_valid; back-to-back accepts SHALL sustain 1 instr/cycle while i_ready=1.
REQ-010 Opcode controls SHALL be: o_branch for B; o_jal for JAL; o_jalr for JALR; o_selop1 for AUIPC or JALR; o_selop2 for R or B; o_wr_en for store; o_resultsrc 10 for JAL/JALR, 01 for load, else 00.
REQ-011 o_rf_wr SHALL be 1 except for B, store, illegal, or rd==0, where it SHALL be 0.
REQ-012 ALU codes SHALL be the existing 4-bit codes of the parameters header zero-extended to 5 bits; invalid SHALL be 5'h1F.
REQ-013 R/I-type SHALL decode ADD/SUB/SLL/SLT/SLTU/XOR/SRL/SRA/OR/AND by funct3 and instr[30]; ADDI ignores instr[30]; SUB with instr[30]=0 SHALL be ADD; any other R funct7 SHALL be illegal except M.
REQ-014 Load/store/JALR/AUIPC SHALL use ADD; JAL/LUI SHALL use BUF; B-type SHALL use EQ (BEQ/BNE), GE (BLT/BGE), GEU (BLTU/BGEU); funct3 010/011 on B SHALL be illegal.
REQ-015 With EN_M=1, R-type with funct7=0000001 SHALL map funct3 0..7 to codes 5'h10..5'h17 (MUL, MULH, MULHSU, MULHU, DIV, DIVU, REM, REMU).
REQ-016 o_imm SHALL be the I/S/B/U/J immediate per opcode, sign-extended from instr[31] to XLEN; R-type and illegal SHALL give 0.
REQ-017 Unknown opcode or invalid function field SHALL set o_illegal=1, o_alu_ctrl=5'h1F, and force o_wr_en, o_rf_wr, o_branch, o_jal, o_jalr to 0.
REQ-018 o_illegal_cnt SHALL increment by 1 on each accept of an illegal instruction and saturate at 16'hFFFF.

Reset
REQ-019 Asserting i_rst SHALL immediately clear o_valid, o_illegal, o_illegal_cnt and all registered outputs to 0 regardless of clock, including mid-stall.
REQ-020 After i_rst deasserts, o_ready SHALL be 1 and the first accept SHALL occur on the next rising edge with i_valid=1.

Verification
REQ-021 i_instr=32'h00500093 (ADDI x1,x0,5), i_ready=1 -> next cycle o_valid=1, o_alu_ctrl=ADD, o_imm=5, o_rd=1, o_rf_wr=1.
REQ-022 i_instr=32'hFE000EE3 (BEQ x0,x0,-4), XLEN=64 -> o_imm=64'hFFFFFFFFFFFFFFFC, o_branch=1, o_rf_wr=0, o_alu_ctrl=EQ.
REQ-023 i_ready=0 for 3 cycles with o_valid=1 -> outputs unchanged, o_ready=0; i_ready=1 -> next bundle loads same cycle.
REQ-024 i_instr=32'h02208033 (MUL) with EN_M=0 -> o_illegal=1, o_rf_wr=0, o_illegal_cnt=1; with EN_M=1 -> o_alu_ctrl=5'h10, o_illegal=0.
REQ-025 i_flush=1 with i_valid=1 and an illegal instr -> o_valid=0 next cycle, o_illegal_cnt unchanged.
REQ-026 Preload counter to 16'hFFFF via 65535 illegal accepts, then one more -> count stays 16'hFFFF; assert i_rst mid-stall -> all outputs 0 before next edge.

Source files
------------

// File: rtl/pipe_decoder.sv
// pipe_decoder: single-entry registered RV32 decode stage with valid/ready handshake,
// flush, and a saturating count of accepted illegal instructions.
module pipe_decoder #(
   parameter int XLEN = 32,
   parameter bit EN_M = 1'b0
) (
   input  logic            i_clk,
   input  logic            i_rst,
   input  logic            i_valid,
   output logic            o_ready,
   input  logic [31:0]     i_instr,
   input  logic [XLEN-1:0] i_pc,
   input  logic            i_flush,
   output logic            o_valid,
   input  logic            i_ready,
   output logic [XLEN-1:0] o_pc,
   output logic [XLEN-1:0] o_imm,
   output logic [4:0]      o_rs1,
   output logic [4:0]      o_rs2,
   output logic [4:0]      o_rd,
   output logic [4:0]      o_alu_ctrl,
   output logic            o_branch,
   output logic            o_jal,
   output logic            o_jalr,
   output logic            o_selop1,
   output logic            o_selop2,
   output logic            o_wr_en,
   output logic            o_rf_wr,
   output logic [1:0]      o_resultsrc,
   output logic            o_illegal,
   output logic [15:0]     o_illegal_cnt
);
   // 4-bit ALU codes zero-extended; M ops occupy 5'h10..5'h17
   localparam logic [4:0] ALU_ADD  = 5'h00, ALU_SUB = 5'h01, ALU_SLL = 5'h02, ALU_SLT = 5'h03;
   localparam logic [4:0] ALU_SLTU = 5'h04, ALU_XOR = 5'h05, ALU_SRL = 5'h06, ALU_SRA = 5'h07;
   localparam logic [4:0] ALU_OR   = 5'h08, ALU_AND = 5'h09, ALU_BUF = 5'h0A, ALU_EQ  = 5'h0B;
   localparam logic [4:0] ALU_GE   = 5'h0C, ALU_GEU = 5'h0D, ALU_BAD = 5'h1F;
   localparam logic [6:0] OP_R = 7'b0110011, OP_I = 7'b0010011, OP_LD = 7'b0000011, OP_ST = 7'b0100011;
   localparam logic [6:0] OP_B = 7'b1100011, OP_JAL = 7'b1101111, OP_JALR = 7'b1100111;
   localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111;

   typedef struct packed {
      logic [XLEN-1:0] pc;
      logic [XLEN-1:0] imm;
      logic [4:0]      rs1;
      logic [4:0]      rs2;
      logic [4:0]      rd;
      logic [4:0]      alu;
      logic            branch;
      logic            jal;
      logic            jalr;
      logic            selop1;
      logic            selop2;
      logic            wr_en;
      logic            rf_wr;
      logic [1:0]      resultsrc;
      logic            illegal;
   } bundle_t;

   bundle_t     dec, bundle_d, bundle_q;
   logic        valid_d, valid_q, accept;
   logic [15:0] cnt_d, cnt_q;
   logic [31:0] imm32;
   logic        ill;
   logic [6:0]  op, f7;
   logic [2:0]  f3;

   function automatic logic [4:0] alu_f3(input logic [2:0] f, input logic alt);
      case (f)
         3'd0:    alu_f3 = alt ? ALU_SUB : ALU_ADD;
         3'd1:    alu_f3 = ALU_SLL;
         3'd2:    alu_f3 = ALU_SLT;
         3'd3:    alu_f3 = ALU_SLTU;
         3'd4:    alu_f3 = ALU_XOR;
         3'd5:    alu_f3 = alt ? ALU_SRA : ALU_SRL;
         3'd6:    alu_f3 = ALU_OR;
         default: alu_f3 = ALU_AND;
      endcase
   endfunction

   assign op = i_instr[6:0];
   assign f3 = i_instr[14:12];
   assign f7 = i_instr[31:25];

   always_comb begin
      dec = '0;
      dec.pc = i_pc;
      dec.rs1 = i_instr[19:15];
      dec.rs2 = i_instr[24:20];
      dec.rd = i_instr[11:7];
      dec.alu = ALU_ADD;
      imm32 = '0;
      ill = 1'b0;
      case (op)
         OP_R: begin
            dec.selop2 = 1'b1;
            if (f7 == 7'b0000000) dec.alu = alu_f3(f3, 1'b0);
            else if (f7 == 7'b0100000 && (f3 == 3'd0 || f3 == 3'd5)) dec.alu = alu_f3(f3, 1'b1);
            else if (EN_M && f7 == 7'b0000001) dec.alu = {2'b10, f3};
            else ill = 1'b1;
         end
         OP_I: begin
            imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            dec.alu = alu_f3(f3, f3 == 3'd5 && i_instr[30]);
            ill = (f3 == 3'd1 && f7 != 7'b0000000) ||
                  (f3 == 3'd5 && f7 != 7'b0000000 && f7 != 7'b0100000);
         end
         OP_LD: begin
            imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            dec.resultsrc = 2'b01;
            ill = f3 == 3'd3 || f3 == 3'd6 || f3 == 3'd7;
         end
         OP_ST: begin
            imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
            dec.wr_en = 1'b1;
            ill = f3 > 3'd2;
         end
         OP_B: begin
            imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7], i_instr[30:25], i_instr[11:8], 1'b0};
            dec.branch = 1'b1;
            dec.selop2 = 1'b1;
            dec.alu = !f3[2] ? ALU_EQ : f3[1] ? ALU_GEU : ALU_GE;
            ill = f3[2:1] == 2'b01;
         end
         OP_JAL: begin
            imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12], i_instr[20], i_instr[30:21], 1'b0};
            dec.jal = 1'b1;
            dec.resultsrc = 2'b10;
            dec.alu = ALU_BUF;
         end
         OP_JALR: begin
            imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
            dec.jalr = 1'b1;
            dec.selop1 = 1'b1;
            dec.resultsrc = 2'b10;
            ill = f3 != 3'd0;
         end
         OP_LUI: begin
            imm32 = {i_instr[31:12], 12'h000};
            dec.alu = ALU_BUF;
         end
         OP_AUIPC: begin
            imm32 = {i_instr[31:12], 12'h000};
            dec.selop1 = 1'b1;
         end
         default: ill = 1'b1;
      endcase
      dec.imm = XLEN'($signed(imm32));
      dec.rf_wr = op != OP_B && op != OP_ST && dec.rd != 5'd0;
      // An illegal word keeps only its register indices and PC; every control goes inert
      if (ill) begin
         dec.imm = '0;
         dec.alu = ALU_BAD;
         {dec.branch, dec.jal, dec.jalr, dec.selop1, dec.selop2, dec.wr_en, dec.rf_wr} = '0;
         dec.resultsrc = 2'b00;
         dec.illegal = 1'b1;
      end
   end

   assign o_ready = !valid_q || i_ready;
   assign accept = i_valid && o_ready && !i_flush;

   always_comb begin
      bundle_d = accept ? dec : bundle_q;
      valid_d = i_flush ? 1'b0 : accept ? 1'b1 : i_ready ? 1'b0 : valid_q;
      cnt_d = (accept && dec.illegal && cnt_q != 16'hFFFF) ? cnt_q + 16'd1 : cnt_q;
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         bundle_q <= '0;
         valid_q <= 1'b0;
         cnt_q <= '0;
      end else begin
         bundle_q <= bundle_d;
         valid_q <= valid_d;
         cnt_q <= cnt_d;
      end
   end

   assign o_valid = valid_q;
   assign o_pc = bundle_q.pc;
   assign o_imm = bundle_q.imm;
   assign o_rs1 = bundle_q.rs1;
   assign o_rs2 = bundle_q.rs2;
   assign o_rd = bundle_q.rd;
   assign o_alu_ctrl = bundle_q.alu;
   assign o_branch = bundle_q.branch;
   assign o_jal = bundle_q.jal;
   assign o_jalr = bundle_q.jalr;
   assign o_selop1 = bundle_q.selop1;
   assign o_selop2 = bundle_q.selop2;
   assign o_wr_en = bundle_q.wr_en;
   assign o_rf_wr = bundle_q.rf_wr;
   assign o_resultsrc = bundle_q.resultsrc;
   assign o_illegal = bundle_q.illegal;
   assign o_illegal_cnt = cnt_q;
endmodule

// File: tb/tb_pipe_decoder.sv
// tb_pipe_decoder: directed vectors against a 64-bit base-ISA decoder and a 32-bit M-enabled one.
module tb_pipe_decoder;
   logic        clk = 1'b0, rst = 1'b1, valid = 1'b0, flush = 1'b0, ready = 1'b1;
   logic [31:0] instr = '0;
   logic [63:0] pc = '0;
   int          total = 0, bad = 0, exp_cnt = 0;

   logic        o_ready, o_valid, o_branch, o_jal, o_jalr, o_selop1, o_selop2, o_wr_en, o_rf_wr, o_illegal;
   logic [63:0] o_pc, o_imm;
   logic [4:0]  o_rs1, o_rs2, o_rd, o_alu;
   logic [1:0]  o_res;
   logic [15:0] o_cnt;

   logic        m_ready, m_valid, m_branch, m_jal, m_jalr, m_selop1, m_selop2, m_wr_en, m_rf_wr, m_illegal;
   logic [31:0] m_pc, m_imm;
   logic [4:0]  m_rs1, m_rs2, m_rd, m_alu;
   logic [1:0]  m_res;
   logic [15:0] m_cnt;

   always #5 clk = ~clk;

   pipe_decoder #(.XLEN(64), .EN_M(1'b0)) dut (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(o_ready), .i_instr(instr), .i_pc(pc),
      .i_flush(flush), .o_valid(o_valid), .i_ready(ready), .o_pc(o_pc), .o_imm(o_imm),
      .o_rs1(o_rs1), .o_rs2(o_rs2), .o_rd(o_rd), .o_alu_ctrl(o_alu), .o_branch(o_branch),
      .o_jal(o_jal), .o_jalr(o_jalr), .o_selop1(o_selop1), .o_selop2(o_selop2), .o_wr_en(o_wr_en),
      .o_rf_wr(o_rf_wr), .o_resultsrc(o_res), .o_illegal(o_illegal), .o_illegal_cnt(o_cnt));

   pipe_decoder #(.XLEN(32), .EN_M(1'b1)) dut_m (
      .i_clk(clk), .i_rst(rst), .i_valid(valid), .o_ready(m_ready), .i_instr(instr), .i_pc(pc[31:0]),
      .i_flush(flush), .o_valid(m_valid), .i_ready(ready), .o_pc(m_pc), .o_imm(m_imm),
      .o_rs1(m_rs1), .o_rs2(m_rs2), .o_rd(m_rd), .o_alu_ctrl(m_alu), .o_branch(m_branch),
      .o_jal(m_jal), .o_jalr(m_jalr), .o_selop1(m_selop1), .o_selop2(m_selop2), .o_wr_en(m_wr_en),
      .o_rf_wr(m_rf_wr), .o_resultsrc(m_res), .o_illegal(m_illegal), .o_illegal_cnt(m_cnt));

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%h exp=%h", tag, got, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [31:0] ins, input logic [63:0] a);
      valid = 1'b1;
      instr = ins;
      pc = a;
      step();
   endtask

   initial begin
      #3;
      check("rst_valid", o_valid, 0);
      check("rst_cnt", o_cnt, 0);
      check("rst_imm", o_imm, 0);
      step();
      rst = 1'b0;
      #1;
      check("post_rst_ready", o_ready, 1);

      send(32'h00500093, 64'h100);
      check("addi_valid", o_valid, 1);
      check("addi_alu", o_alu, 5'h00);
      check("addi_imm", o_imm, 64'd5);
      check("addi_rd", o_rd, 5'd1);
      check("addi_rf_wr", o_rf_wr, 1);
      check("addi_pc", o_pc, 64'h100);
      check("addi_imm32", m_imm, 32'd5);

      send(32'hFE000EE3, 64'h104);
      check("beq_imm", o_imm, 64'hFFFFFFFFFFFFFFFC);
      check("beq_branch", o_branch, 1);
      check("beq_rf_wr", o_rf_wr, 0);
      check("beq_alu", o_alu, 5'h0B);
      check("beq_selop2", o_selop2, 1);

      send(32'h02208033, 64'h108);
      exp_cnt++;
      check("mul_ill", o_illegal, 1);
      check("mul_rf_wr", o_rf_wr, 0);
      check("mul_alu", o_alu, 5'h1F);
      check("mul_cnt", o_cnt, exp_cnt);
      check("mul_m_alu", m_alu, 5'h10);
      check("mul_m_ill", m_illegal, 0);
      check("mul_m_cnt", m_cnt, 0);

      ready = 1'b0;
      instr = 32'h123452B7;
      pc = 64'h10C;
      for (int i = 0; i < 3; i++) begin
         step();
         check("stall_ready", o_ready, 0);
         check("stall_valid", o_valid, 1);
         check("stall_ill", o_illegal, 1);
         check("stall_pc", o_pc, 64'h108);
         check("stall_cnt", o_cnt, exp_cnt);
      end
      ready = 1'b1;
      #1;
      check("unstall_ready", o_ready, 1);
      step();
      check("lui_imm", o_imm, 64'h12345000);
      check("lui_alu", o_alu, 5'h0A);
      check("lui_rd", o_rd, 5'd5);
      check("lui_rf_wr", o_rf_wr, 1);
      check("lui_ill", o_illegal, 0);

      valid = 1'b0;
      step();
      check("drain_valid", o_valid, 0);

      valid = 1'b1;
      flush = 1'b1;
      instr = 32'h02208033;
      step();
      flush = 1'b0;
      check("flush_valid", o_valid, 0);
      check("flush_cnt", o_cnt, exp_cnt);

      send(32'h008000EF, 64'h200);
      check("jal_imm", o_imm, 64'd8);
      check("jal_ctl", {o_jal, o_jalr, o_res, o_rf_wr, o_alu}, {1'b1, 1'b0, 2'b10, 1'b1, 5'h0A});
      send(32'h00008067, 64'h204);
      check("jalr_ctl", {o_jal, o_jalr, o_selop1, o_res, o_rf_wr, o_rs1}, {1'b0, 1'b1, 1'b1, 2'b10, 1'b0, 5'd1});
      send(32'h0020A023, 64'h208);
      check("sw_ctl", {o_wr_en, o_rf_wr, o_alu, o_rs2}, {1'b1, 1'b0, 5'h00, 5'd2});
      send(32'h402081B3, 64'h20C);
      check("sub_ctl", {o_alu, o_selop2, o_rd, o_imm}, {5'h01, 1'b1, 5'd3, 64'd0});
      send(32'h4030D213, 64'h210);
      check("srai_ctl", {o_alu, o_imm}, {5'h07, 64'h403});
      send(32'h0000007F, 64'h214);
      exp_cnt++;
      check("unk_ill", {o_illegal, o_alu, o_wr_en, o_rf_wr, o_branch, o_jal, o_jalr}, {1'b1, 5'h1F, 5'b0});
      check("unk_cnt", o_cnt, exp_cnt);

      instr = 32'hFFFFFFFF;
      repeat (65535 - exp_cnt) step();
      check("sat_reach", o_cnt, 16'hFFFF);
      step();
      check("sat_hold", o_cnt, 16'hFFFF);

      ready = 1'b0;
      step();
      check("pre_rst_valid", o_valid, 1);
      rst = 1'b1;
      #2;
      check("arst_valid", o_valid, 0);
      check("arst_cnt", o_cnt, 0);
      check("arst_ill", o_illegal, 0);
      check("arst_alu", o_alu, 0);
      check("arst_pc", o_pc, 0);
      check("arst_ready", o_ready, 1);
      step();
      rst = 1'b0;
      ready = 1'b1;
      send(32'h00500093, 64'h300);
      check("rst_first_accept", {o_valid, o_pc}, {1'b1, 64'h300});

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
